// File: rtl/gpio_irq_wb.sv
// Wishbone GPIO block for iCE40: N registered pads with set/clear/toggle outputs,
// a synchronised input path with per-bit rise/fall interrupt capture, a level IRQ,
// a free-running cycle counter and an LCD frame-mark edge counter.
module gpio_irq_wb #(
  parameter int unsigned N              = 12,
  parameter logic [31:0] IRQ_DEFAULT_EN = 32'h0
) (
  input  logic         clk,
  input  logic         rst,
  inout  wire  [N-1:0] gpio,
  input  logic         lcd_fmark,
  input  logic [31:0]  wb_wdata,
  output logic [31:0]  wb_rdata,
  input  logic [3:0]   wb_addr,
  input  logic         wb_we,
  input  logic         wb_cyc,
  output logic         wb_ack,
  output logic         irq
);

  localparam logic [3:0] AddrOe      = 4'd0;
  localparam logic [3:0] AddrOut     = 4'd1;
  localparam logic [3:0] AddrOutSet  = 4'd2;
  localparam logic [3:0] AddrOutClr  = 4'd3;
  localparam logic [3:0] AddrOutTgl  = 4'd4;
  localparam logic [3:0] AddrIn      = 4'd5;
  localparam logic [3:0] AddrIrqEn   = 4'd6;
  localparam logic [3:0] AddrIrqRise = 4'd7;
  localparam logic [3:0] AddrIrqFall = 4'd8;
  localparam logic [3:0] AddrIrqStat = 4'd9;
  localparam logic [3:0] AddrCycle   = 4'd10;
  localparam logic [3:0] AddrFrame   = 4'd11;

  // Bus state
  logic        ack_q;
  logic [15:0] wr_sel_q;   // one-hot write strobe, only ever set during the ack cycle
  logic [31:0] rdata_q;
  logic [31:0] rd_mux;
  logic        req;

  // Architectural registers
  logic [N-1:0] oe_q, oe_d;
  logic [N-1:0] out_q, out_d;
  logic [N-1:0] en_q, en_d;
  logic [N-1:0] rise_en_q, rise_en_d;
  logic [N-1:0] fall_en_q, fall_en_d;
  logic [N-1:0] status_q, status_d;
  logic         irq_q;

  // Pad registers (the SB_IO input/output/OE flops) and input synchroniser
  logic [N-1:0] pad_oe_q, pad_out_q, pad_in_q;
  logic [N-1:0] in_q, prev_q;
  logic [N-1:0] evt;
  logic [N-1:0] wdata_n;

  // Counters
  logic [31:0] cycle_q;
  logic [15:0] frame_q;
  logic        fm_s1_q, fm_s2_q, fm_prev_q;

  // Bits above N are never looked at.
  logic unused_wdata;
  assign unused_wdata = ^wb_wdata;

  assign wdata_n  = wb_wdata[N-1:0];
  assign req      = wb_cyc & ~ack_q;
  assign wb_ack   = ack_q;
  assign wb_rdata = rdata_q;
  assign irq      = irq_q;

  // Pad drivers: tristate from the registered OE/output bits.
  for (genvar i = 0; i < N; i++) begin : g_pad
    assign gpio[i] = pad_oe_q[i] ? pad_out_q[i] : 1'bz;
  end

  // Read mux, sampled in the request cycle so data is registered into the ack cycle.
  always_comb begin
    rd_mux = '0;
    case (wb_addr)
      AddrOe:                                rd_mux[N-1:0] = oe_q;
      AddrOut, AddrOutSet, AddrOutClr,
      AddrOutTgl:                            rd_mux[N-1:0] = out_q;
      AddrIn:                                rd_mux[N-1:0] = in_q;
      AddrIrqEn:                             rd_mux[N-1:0] = en_q;
      AddrIrqRise:                           rd_mux[N-1:0] = rise_en_q;
      AddrIrqFall:                           rd_mux[N-1:0] = fall_en_q;
      AddrIrqStat:                           rd_mux[N-1:0] = status_q;
      AddrCycle:                             rd_mux        = cycle_q;
      AddrFrame:                             rd_mux        = {16'h0, frame_q};
      default:                               rd_mux        = '0;
    endcase
  end

  // Bus handshake: one ack per access with one wait state; strobes drop outside a request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q    <= 1'b0;
      wr_sel_q <= '0;
      rdata_q  <= '0;
    end else begin
      ack_q    <= req;
      wr_sel_q <= (req & wb_we) ? (16'h1 << wb_addr) : 16'h0;
      rdata_q  <= req ? rd_mux : 32'h0;
    end
  end

  // Edge events from the synchronised input against its one-cycle history.
  assign evt = (in_q & ~prev_q & rise_en_q) | (~in_q & prev_q & fall_en_q);

  // Register next state; writes commit at the edge ending the ack cycle.
  always_comb begin
    oe_d      = oe_q;
    out_d     = out_q;
    en_d      = en_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    if (wr_sel_q[AddrOe])      oe_d      = wdata_n;
    if (wr_sel_q[AddrOut])     out_d     = wdata_n;
    if (wr_sel_q[AddrOutSet])  out_d     = out_q | wdata_n;
    if (wr_sel_q[AddrOutClr])  out_d     = out_q & ~wdata_n;
    if (wr_sel_q[AddrOutTgl])  out_d     = out_q ^ wdata_n;
    if (wr_sel_q[AddrIrqEn])   en_d      = wdata_n;
    if (wr_sel_q[AddrIrqRise]) rise_en_d = wdata_n;
    if (wr_sel_q[AddrIrqFall]) fall_en_d = wdata_n;
    // A new event on a bit being cleared wins, so no edge is lost.
    status_d = (status_q & ~(wr_sel_q[AddrIrqStat] ? wdata_n : '0)) | evt;
  end

  // Control/status registers and the registered IRQ level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_q      <= '0;
      out_q     <= '0;
      en_q      <= IRQ_DEFAULT_EN[N-1:0];
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      oe_q      <= oe_d;
      out_q     <= out_d;
      en_q      <= en_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      irq_q     <= |(status_q & en_q);
    end
  end

  // Pad I/O flops plus one fabric stage giving a 2-flop input synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_oe_q  <= '0;
      pad_out_q <= '0;
      pad_in_q  <= '0;
      in_q      <= '0;
      prev_q    <= '0;
    end else begin
      pad_oe_q  <= oe_q;
      pad_out_q <= out_q;
      pad_in_q  <= gpio;
      in_q      <= pad_in_q;
      prev_q    <= in_q;
    end
  end

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  // Frame-mark synchroniser and rising-edge counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fm_s1_q   <= 1'b0;
      fm_s2_q   <= 1'b0;
      fm_prev_q <= 1'b0;
      frame_q   <= '0;
    end else begin
      fm_s1_q   <= lcd_fmark;
      fm_s2_q   <= fm_s1_q;
      fm_prev_q <= fm_s2_q;
      if (fm_s2_q & ~fm_prev_q) frame_q <= frame_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_gpio_irq_wb.sv
// Directed bench for gpio_irq_wb with hand-computed expectations.
module tb_gpio_irq_wb;
  localparam int N = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire [N-1:0] gpio;
  logic        lcd_fmark = 1'b0;
  logic [31:0] wb_wdata = '0;
  logic [31:0] wb_rdata;
  logic [3:0]  wb_addr = '0;
  logic        wb_we = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_ack;
  logic        irq;

  logic [N-1:0] pad_en  = '0;
  logic [N-1:0] pad_drv = '0;

  int          n_checks = 0;
  int          n_pass = 0;
  int          lat;
  logic [31:0] rd, c1, c2;
  int          rst_addrs [5] = '{0, 1, 6, 9, 12};

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_drv
    assign gpio[i] = pad_en[i] ? pad_drv[i] : 1'bz;
  end

  gpio_irq_wb #(.N(N), .IRQ_DEFAULT_EN(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .gpio      (gpio),
    .lcd_fmark (lcd_fmark),
    .wb_wdata  (wb_wdata),
    .wb_rdata  (wb_rdata),
    .wb_addr   (wb_addr),
    .wb_we     (wb_we),
    .wb_cyc    (wb_cyc),
    .wb_ack    (wb_ack),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One bus access; returns read data from the ack cycle, leaves the bench just after commit.
  task automatic wb_xfer(input logic [3:0] a, input logic we, input logic [31:0] d,
                         output logic [31:0] rdat);
    int cnt;
    @(negedge clk);
    wb_cyc = 1'b1; wb_addr = a; wb_we = we; wb_wdata = d;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!wb_ack && cnt < 4);
    lat  = cnt;
    rdat = wb_rdata;
    if (!wb_ack) check("ack_timeout", {31'h0, wb_ack}, 32'h1);
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(a, 1'b1, d, dummy);
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] rdat);
    wb_xfer(a, 1'b0, 32'h0, rdat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_ack", {31'h0, wb_ack}, 32'h0);
    check("rst_rdata", wb_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    foreach (rst_addrs[k]) begin
      wb_read(rst_addrs[k][3:0], rd);
      check("reset_read", rd, 32'h0);
      check("ack_latency", 32'(lat), 32'd1);
    end
    check("ack_after", {31'h0, wb_ack}, 32'h0);
    check("rdata_idle", wb_rdata, 32'h0);

    // Atomic output updates and pad loopback
    wb_write(4'd0, 32'hFFF);
    wb_write(4'd1, 32'h0F0);
    wb_write(4'd2, 32'h00F);
    wb_read(4'd1, rd);  check("out_set", rd, 32'h0FF);
    wb_write(4'd3, 32'h030);
    wb_read(4'd3, rd);  check("out_clr", rd, 32'h0CF);
    wb_write(4'd4, 32'h801);
    check("pad_lag", 32'(gpio), 32'h0CF);
    @(posedge clk); #1;
    check("pad_out", 32'(gpio), 32'h8CE);
    wb_read(4'd1, rd);  check("out_tgl", rd, 32'h8CE);
    wb_read(4'd4, rd);  check("out_tgl_alias", rd, 32'h8CE);
    wb_read(4'd5, rd);  check("in_loopback", rd, 32'h8CE);
    wb_write(4'd2, 32'hFFFF_0000);
    wb_read(4'd1, rd);  check("out_upper_ignored", rd, 32'h8CE);
    wb_write(4'd12, 32'h123);
    wb_read(4'd12, rd); check("addr12_zero", rd, 32'h0);
    wb_write(4'd5, 32'h0);
    wb_read(4'd5, rd);  check("in_ro", rd, 32'h8CE);

    // Rising-edge capture, enable, W1C
    wb_write(4'd0, 32'h0);
    repeat (2) @(negedge clk);
    pad_en = '1;
    repeat (3) @(negedge clk);
    wb_write(4'd7, 32'h008);
    @(negedge clk);
    pad_drv[3] = 1'b1;
    wb_read(4'd9, rd);  check("status_2clk", rd, 32'h0);
    wb_read(4'd9, rd);  check("status_rise", rd, 32'h008);
    check("irq_masked", {31'h0, irq}, 32'h0);
    wb_read(4'd5, rd);  check("in_pad", rd, 32'h008);
    wb_write(4'd6, 32'h008);
    check("irq_en_commit", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    check("irq_en_next", {31'h0, irq}, 32'h1);
    wb_write(4'd9, 32'h008);
    check("irq_w1c_commit", {31'h0, irq}, 32'h1);
    @(posedge clk); #1;
    check("irq_w1c_next", {31'h0, irq}, 32'h0);
    wb_read(4'd9, rd);  check("status_cleared", rd, 32'h0);

    // Falling-edge event coinciding with W1C of the same bit
    wb_write(4'd8, 32'h020);
    wb_write(4'd6, 32'h020);
    @(negedge clk); pad_drv[5] = 1'b1;
    repeat (4) @(negedge clk);
    wb_read(4'd9, rd);  check("rise5_no_event", rd, 32'h0);
    @(negedge clk); pad_drv[5] = 1'b0;
    repeat (4) @(negedge clk);
    wb_read(4'd9, rd);  check("status_fall", rd, 32'h020);
    check("irq_fall", {31'h0, irq}, 32'h1);
    @(negedge clk); pad_drv[5] = 1'b1;
    repeat (4) @(negedge clk);
    @(negedge clk); pad_drv[5] = 1'b0;
    wb_write(4'd9, 32'h020);
    @(posedge clk); #1;
    check("irq_event_wins", {31'h0, irq}, 32'h1);
    wb_read(4'd9, rd);  check("status_event_wins", rd, 32'h020);

    // Frame-mark counter
    @(negedge clk); lcd_fmark = 1'b1;
    repeat (100) @(negedge clk);
    lcd_fmark = 1'b0;
    repeat (3) @(negedge clk);
    repeat (3) begin
      lcd_fmark = 1'b1;
      repeat (2) @(negedge clk);
      lcd_fmark = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    wb_read(4'd11, rd); check("frame_count", rd, 32'h4);
    @(negedge clk);
    force dut.frame_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_q;
    wb_read(4'd11, rd); check("frame_preload", rd, 32'hFFFF);
    @(negedge clk); lcd_fmark = 1'b1;
    repeat (2) @(negedge clk);
    lcd_fmark = 1'b0;
    repeat (4) @(negedge clk);
    wb_read(4'd11, rd); check("frame_wrap", rd, 32'h0);

    // Cycle counter: back-to-back reads are two clocks apart
    wb_read(4'd10, c1);
    wb_read(4'd10, c2);
    check("cycle_step", c2 - c1, 32'd2);

    // Asynchronous reset during an in-flight write to OUT
    @(negedge clk);
    wb_cyc = 1'b1; wb_addr = 4'd1; wb_we = 1'b1; wb_wdata = 32'h5A5;
    @(posedge clk); #1;
    check("inflight_ack", {31'h0, wb_ack}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_ack", {31'h0, wb_ack}, 32'h0);
    check("async_irq", {31'h0, irq}, 32'h0);
    check("async_rdata", wb_rdata, 32'h0);
    repeat (2) begin
      @(posedge clk); #1;
      check("ack_in_rst", {31'h0, wb_ack}, 32'h0);
    end
    @(negedge clk);
    wb_cyc = 1'b0; wb_we = 1'b0; rst = 1'b0;
    wb_read(4'd10, rd); check("cycle_restart", rd, 32'h1);
    wb_read(4'd1, rd);  check("out_after_rst", rd, 32'h0);
    wb_read(4'd9, rd);  check("status_after_rst", rd, 32'h0);
    wb_read(4'd6, rd);  check("en_after_rst", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpio_irq_wb.md
Name: gpio_irq_wb

Overview:
Wishbone GPIO and timing peripheral for the iCE40 designs, generalising the team's fixed 12-bit GPIO/counter block. Provides N bidirectional pads through registered SB_IO, atomic set/clear/toggle of outputs, a synchronised input path with per-bit rising/falling-edge interrupt detection, and a level IRQ output to the soft-core. Also keeps a free-running cycle counter and an edge-counted LCD frame-mark counter.

Parameters:
N, 12, number of GPIO pads (1..32); register bits [31:N] read 0 and ignore writes
IRQ_DEFAULT_EN, 0, reset value of IRQ_EN register (N bits)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
gpio  inout  N  GPIO pads (SB_IO, registered input, registered output and OE)
lcd_fmark  input  1  LCD frame mark, asynchronous to clk
wb_wdata  input  32  write data
wb_rdata  output  32  read data, zero except during ack cycle
wb_addr  input  4  word address
wb_we  input  1  write enable
wb_cyc  input  1  cycle request
wb_ack  output  1  acknowledge
irq  output  1  level interrupt, registered

Behaviour:
- Reset (async, rst=1): wb_ack=0, wb_rdata=0, irq=0, OE=0, OUT=0, IRQ_RISE=0, IRQ_FALL=0, IRQ_STATUS=0, IRQ_EN=IRQ_DEFAULT_EN, counters=0, sync/edge history regs=0. Reset mid-transaction aborts it; no ack issued while rst=1.
- Bus: wb_ack <= wb_cyc & ~wb_ack (one ack per access, 1 wait state, back-to-back access gets ack every 2nd cycle). Address decode and write strobes registered, cleared when ~wb_cyc | wb_ack. Write takes effect on the clock edge ending the ack cycle; read data registered, valid only in the ack cycle, 0 otherwise.
- Register map (wb_addr): 0 OE rw; 1 OUT rw; 2 OUT_SET wo (OUT |= wdata), reads OUT; 3 OUT_CLR wo (OUT &= ~wdata), reads OUT; 4 OUT_TGL wo (OUT ^= wdata), reads OUT; 5 IN ro; 6 IRQ_EN rw; 7 IRQ_RISE rw; 8 IRQ_FALL rw; 9 IRQ_STATUS read / write-1-to-clear; 10 CYCLE ro 32b; 11 FRAME ro {16'h0, cnt}; 12..15 read 0, writes ignored. Writes to ro addresses ignored.
- Input path: SB_IO input register + one fabric flop = 2-stage synchroniser -> IN. Edge history flop holds previous IN. Pad-to-IN latency: 2 clk.
- Edge detect: rise[i]=IN[i]&~prev[i]; fall[i]=~IN[i]&prev[i]. event[i]=(rise[i]&IRQ_RISE[i])|(fall[i]&IRQ_FALL[i]). IRQ_STATUS[i] set by event regardless of IRQ_EN (status observable by polling). Same-cycle W1C and new event on same bit: event wins, bit stays 1.
- irq <= |(IRQ_STATUS & IRQ_EN), one register stage; deasserts 1 clk after the W1C commit when no bit remains pending. Enabling IRQ_EN with a pending status bit raises irq one cycle later.
- OE/OUT drive SB_IO registered output and OE: pad changes 1 clk after register update.
- CYCLE: 32-bit, +1 every clk, wraps 0xFFFFFFFF -> 0.
- FRAME: lcd_fmark 2-flop synchronised, counts rising edges only (level held high counts once), 16-bit wrap 0xFFFF -> 0.

Test Plan:
- Reset then read addr 0,1,6,9,12 -> all 0; ack exactly 1 cycle after cyc rises, rdata 0 outside ack.
- Write OUT=0x0F0, OUT_SET=0x00F, OUT_CLR=0x030, OUT_TGL=0x801 -> OUT reads 0x8CE; with OE=0xFFF pads show 0x8CE one clk after final commit.
- Drive gpio[3] 0->1 with IRQ_RISE=0x008, IRQ_EN=0 -> IRQ_STATUS=0x008 after 3 clk, irq=0; write IRQ_EN=0x008 -> irq=1 next cycle; W1C 0x008 -> irq=0.
- Toggle gpio[5] on the exact cycle a W1C of bit 5 commits, IRQ_FALL=0x020 -> bit 5 remains set, irq stays 1.
- Hold lcd_fmark high 100 clk, pulse it 3 more times -> FRAME reads 4; preload to 0xFFFF via 65535 pulses (or force) then one pulse -> 0.
- Assert rst asynchronously during an in-flight write to OUT -> no ack, OUT=0, irq=0 immediately; CYCLE restarts from 0.
